fetch_unit: RTL

- Instruction-fetch stage directly upstream of the control/decode stage.
- Owns the PC register and issues in-order requests to instruction memory over a valid/ready request channel with variable-latency responses.
- Buffers returned instructions in a small queue and hands {instr, pc, opcode} to decode via a valid/ready handshake.
- Applies redirects from branch resolution (pcSrc path), flushing the queue and squashing stale responses.

---
 rtl/fetch_unit_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode types: opcode and control encodings, fetch queue entry,
// and the constants decode-side logic and benches use to recognise opcodes and idle slots.
package fetch_unit_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0] OPCODE_MASK = 32'h0000_007F;
  localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;

  typedef logic [6:0] opcode_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } control_out_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic opcode_t opcode_of(input logic [31:0] instr);
    opcode_of = opcode_t'(instr & OPCODE_MASK);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; holds the instruction queue and the in-flight PC tags.
// Storage resets to zero so the head output is defined straight out of reset.
module fetch_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // accept a push when full only if a pop frees the slot in the same cycle
  always_comb begin
    do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
    do_push_s = push && ((count_r != CNT_FULL) || do_pop_s);
  end

  // pointer, occupancy and storage update; flush discards contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited in-order memory requests,
// queues returned words for decode and squashes stale responses after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                WIDTH    = 64,
  parameter logic [WIDTH-1:0]  RESET_PC = {WIDTH{1'b0}},
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WIDTH-1:0]  imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [WIDTH-1:0]  redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [WIDTH-1:0]  if_pc,
  output opcode_t           if_opcode
);
  localparam int               CW         = $clog2(QDEPTH) + 1;
  localparam int               EW         = 32 + WIDTH;
  localparam logic [CW:0]      CREDITS    = (CW+1)'(QDEPTH);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-3){1'b0}}, 3'b100};

  logic [WIDTH-1:0] pc_r;
  logic [CW-1:0]    drop_cnt_r;
  logic [CW-1:0]    drop_cnt_nxt_s;
  logic [CW-1:0]    in_flight_s;
  logic [CW-1:0]    q_count_s;
  logic [WIDTH-1:0] tag_pc_s;
  logic [EW-1:0]    q_head_s;
  logic             credit_ok_s;
  logic             req_fire_s;
  logic             q_push_s;
  logic             q_pop_s;

  // the tag FIFO occupancy is the in-flight count: push on request, pop on response
  fetch_fifo #(.DW(WIDTH), .DEPTH(QDEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire_s),
    .push_data (pc_r),
    .pop       (imem_rsp_valid),
    .pop_data  (tag_pc_s),
    .count     (in_flight_s)
  );

  fetch_fifo #(.DW(EW), .DEPTH(QDEPTH)) u_instr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (q_push_s),
    .push_data ({imem_rsp_data, tag_pc_s}),
    .pop       (q_pop_s),
    .pop_data  (q_head_s),
    .count     (q_count_s)
  );

  // request/response/dequeue handshakes; a redirect cycle blocks all three
  always_comb begin
    credit_ok_s    = ({1'b0, in_flight_s} + {1'b0, q_count_s}) < CREDITS;
    imem_req_valid = rst_n && credit_ok_s && !redirect_valid;
    imem_req_addr  = pc_r;
    req_fire_s     = imem_req_valid && imem_req_ready;
    if_valid       = rst_n && (q_count_s != {CW{1'b0}}) && !redirect_valid;
    q_pop_s        = if_valid && if_ready;
    q_push_s       = imem_rsp_valid && (drop_cnt_r == {CW{1'b0}}) && !redirect_valid;
    if_instr       = q_head_s[EW-1:WIDTH];
    if_pc          = q_head_s[WIDTH-1:0];
    if_opcode      = opcode_of(q_head_s[EW-1:WIDTH]);
  end

  // on redirect every request still outstanding after this cycle's response is stale
  always_comb begin
    drop_cnt_nxt_s = drop_cnt_r;
    if (redirect_valid) begin
      drop_cnt_nxt_s = in_flight_s - {{(CW-1){1'b0}}, imem_rsp_valid};
    end else if (imem_rsp_valid && (drop_cnt_r != {CW{1'b0}})) begin
      drop_cnt_nxt_s = drop_cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // PC and drop counter state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      drop_cnt_r <= {CW{1'b0}};
    end else begin
      drop_cnt_r <= drop_cnt_nxt_s;
      if (redirect_valid) begin
        pc_r <= redirect_pc & ALIGN_MASK;
      end else if (req_fire_s) begin
        pc_r <= pc_r + PC_STEP;
      end
    end
  end

endmodule
